// File: rtl/btb_pkg.sv
// Shared types and address-split helpers for the direct-mapped branch target buffer.
package btb_pkg;

   localparam int unsigned BTB_PC_WIDTH   = 64;
   localparam int unsigned BTB_ENTRIES    = 64;
   localparam int unsigned BTB_INDEX_BITS = $clog2(BTB_ENTRIES);
   localparam int unsigned BTB_TAG_BITS   = BTB_PC_WIDTH - 2 - BTB_INDEX_BITS;
   // Helpers work on a wide container so any PC_WIDTH up to this fits.
   localparam int unsigned BTB_PC_MAX     = 128;

   typedef struct packed {
      logic                    valid;
      logic [BTB_TAG_BITS-1:0] tag;
      logic [BTB_PC_WIDTH-1:0] target;
   } btb_entry_t;

   function automatic logic [BTB_PC_MAX-1:0] btb_index(input logic [BTB_PC_MAX-1:0] pc,
                                                        input int unsigned index_bits);
      return (pc >> 2) & ((BTB_PC_MAX'(1) << index_bits) - BTB_PC_MAX'(1));
   endfunction

   function automatic logic [BTB_PC_MAX-1:0] btb_tag(input logic [BTB_PC_MAX-1:0] pc,
                                                      input int unsigned index_bits);
      return pc >> (index_bits + 2);
   endfunction

endpackage

// File: rtl/btb_storage.sv
// Entry array for the BTB: one async read port, one sync write port,
// tag-qualified valid clear, and valid clear of every entry on reset.
module btb_storage
   import btb_pkg::*;
#(
   parameter int unsigned ENTRIES    = BTB_ENTRIES,
   parameter int unsigned INDEX_BITS = $clog2(ENTRIES),
   parameter type         entry_t    = btb_entry_t
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [INDEX_BITS-1:0] rd_idx_i,
   output entry_t                rd_entry_o,
   input  logic [INDEX_BITS-1:0] wr_idx_i,
   input  logic                  wr_en_i,
   input  logic                  inv_en_i,
   input  entry_t                wr_entry_i
);

   entry_t mem_q [ENTRIES];

   assign rd_entry_o = mem_q[rd_idx_i];

   // Invalidate only drops the valid bit when the stored tag is the one being resolved.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(ENTRIES); i++) begin
            mem_q[i].valid <= 1'b0;
         end
      end else if (wr_en_i) begin
         mem_q[wr_idx_i] <= wr_entry_i;
      end else if (inv_en_i && mem_q[wr_idx_i].valid &&
                   (mem_q[wr_idx_i].tag == wr_entry_i.tag)) begin
         mem_q[wr_idx_i].valid <= 1'b0;
      end
   end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB: zero-latency lookup for IF, taken/not-taken writeback from EX.
module branch_target_buffer
   import btb_pkg::*;
#(
   parameter int unsigned PC_WIDTH = BTB_PC_WIDTH,
   parameter int unsigned ENTRIES  = BTB_ENTRIES
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [PC_WIDTH-1:0] pc_if,
   input  logic [PC_WIDTH-1:0] pc_ex,
   input  logic                branch_taken_ex,
   input  logic [PC_WIDTH-1:0] target_addr_ex,
   output logic [PC_WIDTH-1:0] predicted_target,
   output logic                hit
);

   localparam int unsigned INDEX_BITS = $clog2(ENTRIES);
   localparam int unsigned TAG_BITS   = PC_WIDTH - 2 - INDEX_BITS;

   typedef struct packed {
      logic                valid;
      logic [TAG_BITS-1:0] tag;
      logic [PC_WIDTH-1:0] target;
   } entry_t;

   logic [INDEX_BITS-1:0] idx_if, idx_ex;
   logic [TAG_BITS-1:0]   tag_if, tag_ex;
   entry_t                rd_entry;
   entry_t                wr_entry;

   assign idx_if = INDEX_BITS'(btb_index(BTB_PC_MAX'(pc_if), INDEX_BITS));
   assign tag_if = TAG_BITS'(btb_tag(BTB_PC_MAX'(pc_if), INDEX_BITS));
   assign idx_ex = INDEX_BITS'(btb_index(BTB_PC_MAX'(pc_ex), INDEX_BITS));
   assign tag_ex = TAG_BITS'(btb_tag(BTB_PC_MAX'(pc_ex), INDEX_BITS));

   always_comb begin
      wr_entry        = '0;
      wr_entry.valid  = 1'b1;
      wr_entry.tag    = tag_ex;
      wr_entry.target = target_addr_ex;
   end

   btb_storage #(
      .ENTRIES    (ENTRIES),
      .INDEX_BITS (INDEX_BITS),
      .entry_t    (entry_t)
   ) u_storage (
      .clk        (clk),
      .reset      (reset),
      .rd_idx_i   (idx_if),
      .rd_entry_o (rd_entry),
      .wr_idx_i   (idx_ex),
      .wr_en_i    (branch_taken_ex),
      .inv_en_i   (!branch_taken_ex),
      .wr_entry_i (wr_entry)
   );

   // Lookup reads pre-write contents; a same-cycle install shows up next cycle.
   always_comb begin
      hit              = rd_entry.valid && (rd_entry.tag == tag_if);
      predicted_target = hit ? rd_entry.target : '0;
   end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: directed table, corner sequences,
// and randomized traffic against an associative-array reference model.
module tb_branch_target_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] pc_if, pc_ex, target_addr_ex;
   logic        branch_taken_ex;
   logic [63:0] predicted_target;
   logic        hit;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: an entry exists in the map only while it is valid.
   logic [63:0] m_tag [int];
   logic [63:0] m_tgt [int];

   branch_target_buffer dut (
      .clk              (clk),
      .reset            (reset),
      .pc_if            (pc_if),
      .pc_ex            (pc_ex),
      .branch_taken_ex  (branch_taken_ex),
      .target_addr_ex   (target_addr_ex),
      .predicted_target (predicted_target),
      .hit              (hit)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [63:0] pc_if;
      logic [63:0] pc_ex;
      logic        taken;
      logic [63:0] tgt;
      logic        exp_hit;
      logic [63:0] exp_tgt;
   } vec_t;

   vec_t tbl[$];

   function automatic int m_idx(input logic [63:0] pc);
      return int'((pc >> 2) % 64);
   endfunction

   function automatic logic [63:0] m_tagof(input logic [63:0] pc);
      return pc >> 8;
   endfunction

   task automatic model_update();
      int i;
      i = m_idx(pc_ex);
      if (reset) begin
         m_tag.delete();
         m_tgt.delete();
      end else if (branch_taken_ex) begin
         m_tag[i] = m_tagof(pc_ex);
         m_tgt[i] = target_addr_ex;
      end else if (m_tag.exists(i) && m_tag[i] == m_tagof(pc_ex)) begin
         m_tag.delete(i);
         m_tgt.delete(i);
      end
   endtask

   task automatic model_lookup(input logic [63:0] pc, output logic eh, output logic [63:0] et);
      int i;
      i  = m_idx(pc);
      eh = m_tag.exists(i) && m_tag[i] == m_tagof(pc);
      et = eh ? m_tgt[i] : 64'h0;
   endtask

   task automatic check(input string name, input logic eh, input logic [63:0] et);
      vectors++;
      if (hit !== eh || predicted_target !== et) begin
         miscompares++;
         $display("FAIL %s pc_if=%h: got hit=%b tgt=%h, want hit=%b tgt=%h",
                  name, pc_if, hit, predicted_target, eh, et);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic drive(input logic r, input logic [63:0] pi, input logic [63:0] pe,
                        input logic tk, input logic [63:0] tg);
      reset = r; pc_if = pi; pc_ex = pe; branch_taken_ex = tk; target_addr_ex = tg;
   endtask

   initial begin
      logic        eh;
      logic [63:0] et;

      drive(1'b1, 64'h0, 64'h0, 1'b0, 64'h0);
      cycle();
      cycle();
      reset = 1'b0;

      // Empty table after reset: nothing hits.
      for (int a = 0; a <= 'h400; a += 4) begin
         pc_if = 64'(a);
         #1;
         check("reset_sweep", 1'b0, 64'h0);
      end

      // Directed rows: outputs checked before the row's clock edge.
      tbl.push_back('{1'b0, 64'h1000, 64'h1000, 1'b1, 64'h2000, 1'b0, 64'h0});
      tbl.push_back('{1'b0, 64'h1000, 64'h0,    1'b0, 64'h0,    1'b1, 64'h2000});
      tbl.push_back('{1'b0, 64'h1004, 64'h0,    1'b0, 64'h0,    1'b0, 64'h0});
      tbl.push_back('{1'b0, 64'h1000, 64'h1100, 1'b1, 64'h3000, 1'b1, 64'h2000});
      tbl.push_back('{1'b0, 64'h1000, 64'h0,    1'b0, 64'h0,    1'b0, 64'h0});
      tbl.push_back('{1'b0, 64'h1100, 64'h0,    1'b0, 64'h0,    1'b1, 64'h3000});
      tbl.push_back('{1'b0, 64'h1100, 64'h1000, 1'b1, 64'h2000, 1'b1, 64'h3000});
      tbl.push_back('{1'b0, 64'h1000, 64'h1004, 1'b1, 64'h4444, 1'b1, 64'h2000});
      tbl.push_back('{1'b0, 64'h1004, 64'h1000, 1'b0, 64'h0,    1'b1, 64'h4444});
      tbl.push_back('{1'b0, 64'h1000, 64'h5004, 1'b0, 64'h0,    1'b0, 64'h0});
      tbl.push_back('{1'b0, 64'h1004, 64'h5000, 1'b0, 64'h0,    1'b1, 64'h4444});
      tbl.push_back('{1'b0, 64'h2040, 64'h2040, 1'b1, 64'h8000, 1'b0, 64'h0});
      tbl.push_back('{1'b0, 64'h2040, 64'h0,    1'b0, 64'h0,    1'b1, 64'h8000});
      tbl.push_back('{1'b1, 64'h2040, 64'h0,    1'b0, 64'h0,    1'b1, 64'h8000});
      tbl.push_back('{1'b0, 64'h2040, 64'h0,    1'b0, 64'h0,    1'b0, 64'h0});
      tbl.push_back('{1'b0, 64'h1004, 64'h0,    1'b0, 64'h0,    1'b0, 64'h0});
      foreach (tbl[k]) begin
         drive(tbl[k].rst, tbl[k].pc_if, tbl[k].pc_ex, tbl[k].taken, tbl[k].tgt);
         #1;
         check($sformatf("table_row%0d", k), tbl[k].exp_hit, tbl[k].exp_tgt);
         cycle();
      end

      // Fill every index, confirm all hit, then reset with a coincident taken write.
      for (int i = 0; i < 64; i++) begin
         drive(1'b0, 64'h0, 64'(i * 4), 1'b1, 64'h10000 + 64'(i * 4));
         cycle();
      end
      branch_taken_ex = 1'b0;
      pc_ex = 64'hFFFF_0000;
      for (int i = 0; i < 64; i++) begin
         pc_if = 64'(i * 4);
         #1;
         check("fill_hit", 1'b1, 64'h10000 + 64'(i * 4));
      end
      drive(1'b1, 64'h40, 64'h40, 1'b1, 64'h9999);
      cycle();
      drive(1'b0, 64'h40, 64'hFFFF_0000, 1'b0, 64'h0);
      for (int i = 0; i < 64; i++) begin
         pc_if = 64'(i * 4);
         #1;
         check("post_reset_miss", 1'b0, 64'h0);
      end

      // Randomized traffic over a narrow address window to force aliasing.
      for (int n = 0; n < 3000; n++) begin
         logic [63:0] pi, pe;
         pi = (64'($urandom_range(0, 3)) << 8) | (64'($urandom_range(0, 7)) << 2);
         pe = (64'($urandom_range(0, 3)) << 8) | (64'($urandom_range(0, 7)) << 2);
         if ($urandom_range(0, 15) == 0) pi[63:40] = 24'($urandom);
         if ($urandom_range(0, 15) == 0) pe[63:40] = 24'($urandom);
         pi[1:0] = 2'($urandom);
         drive(($urandom_range(0, 99) == 0), pi, pe, ($urandom_range(0, 1) == 1),
               {32'($urandom), 32'($urandom)});
         #1;
         model_lookup(pc_if, eh, et);
         check("random", eh, et);
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
